// File: rtl/cci_mpf_prim_ram_rd_flow_pkg.sv
// Shared helpers for the RAM read flow front end.
package cci_mpf_prim_ram_rd_flow_pkg;

  // Bits needed to hold a count that ranges over 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_rd_flow_fifo.sv
// Register-array FIFO holding {data, meta} responses; pointers wrap modulo depth.
module cci_mpf_prim_ram_rd_flow_fifo
  import cci_mpf_prim_ram_rd_flow_pkg::*;
#(
  parameter int N_ENTRIES   = 4,
  parameter int N_DATA_BITS = 72
)
(
  input  logic                                   clk0,
  input  logic                                   reset,
  input  logic                                   enq_en,
  input  logic [N_DATA_BITS-1:0]                 enq_data,
  input  logic                                   deq_en,
  output logic [N_DATA_BITS-1:0]                 first,
  output logic                                   not_empty,
  output logic [cnt_width(N_ENTRIES)-1:0]        cnt
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = cnt_width(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   do_deq;

  assign not_empty = (cnt != '0);
  assign do_deq    = deq_en & not_empty;
  assign first     = mem[rd_ptr];

  always_ff @(posedge clk0) begin
    if (enq_en) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_en) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq_en, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // A push into a full FIFO is only safe when the head leaves on the same edge.
  a_no_overflow: assert property (@(posedge clk0) disable iff (reset)
    !(enq_en && !do_deq && (cnt == CW'(N_ENTRIES))))
    else $error("response FIFO overflow");

endmodule

// File: rtl/cci_mpf_prim_ram_rd_flow.sv
// Flow-controlled read port for the byte-enable dual-port RAM: credit-checked
// issue, fixed-latency tracking pipe and an output FIFO for data plus tag.
module cci_mpf_prim_ram_rd_flow
  import cci_mpf_prim_ram_rd_flow_pkg::*;
#(
  parameter int N_ENTRIES        = 32,
  parameter int N_DATA_BITS      = 64,
  parameter int N_META_BITS      = 8,
  parameter int RAM_READ_LATENCY = 1,
  parameter int N_FIFO_ENTRIES   = 4
)
(
  input  logic                         clk0,
  input  logic                         reset,
  input  logic                         ram_rdy,
  input  logic                         rd_req_en,
  input  logic [$clog2(N_ENTRIES)-1:0] rd_req_addr,
  input  logic [N_META_BITS-1:0]       rd_req_meta,
  output logic                         rd_req_rdy,
  output logic [$clog2(N_ENTRIES)-1:0] ram_addr1,
  input  logic [N_DATA_BITS-1:0]       ram_rdata1,
  output logic                         rsp_valid,
  output logic [N_DATA_BITS-1:0]       rsp_data,
  output logic [N_META_BITS-1:0]       rsp_meta,
  input  logic                         rsp_deq
);

  localparam int CNT_W = cnt_width(N_FIFO_ENTRIES);
  localparam int LAST  = RAM_READ_LATENCY - 1;
  localparam int EW    = N_DATA_BITS + N_META_BITS;

  if (N_META_BITS < 1) begin : g_bad_meta
    $error("N_META_BITS must be at least 1");
  end
  if (RAM_READ_LATENCY < 1) begin : g_bad_lat
    $error("RAM_READ_LATENCY must be at least 1");
  end
  if ((N_FIFO_ENTRIES < RAM_READ_LATENCY + 1) ||
      ((N_FIFO_ENTRIES & (N_FIFO_ENTRIES - 1)) != 0)) begin : g_bad_fifo
    $error("N_FIFO_ENTRIES must be a power of 2 and >= RAM_READ_LATENCY+1");
  end

  logic                        accept;
  logic                        arrive;
  logic [RAM_READ_LATENCY-1:0] vpipe;
  logic [N_META_BITS-1:0]      mpipe [RAM_READ_LATENCY];
  logic [CNT_W-1:0]            inflight_cnt;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [CNT_W:0]              credit_sum;
  logic [EW-1:0]               fifo_first;

  // Every issued read owns a FIFO slot from issue until it is dequeued, so the
  // credit test looks only at registered counts and never at rsp_deq.
  assign credit_sum = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
  assign rd_req_rdy = ram_rdy & ~reset & (credit_sum < (CNT_W+1)'(N_FIFO_ENTRIES));
  assign accept     = rd_req_en & rd_req_rdy;
  assign ram_addr1  = rd_req_addr;
  assign arrive     = vpipe[LAST];

  always_ff @(posedge clk0) begin
    if (reset) begin
      vpipe        <= '0;
      inflight_cnt <= '0;
    end else begin
      vpipe[0] <= accept;
      for (int i = 1; i < RAM_READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
      case ({accept, arrive})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    mpipe[0] <= rd_req_meta;
    for (int i = 1; i < RAM_READ_LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end

  cci_mpf_prim_ram_rd_flow_fifo #(
    .N_ENTRIES   (N_FIFO_ENTRIES),
    .N_DATA_BITS (EW)
  ) u_fifo (
    .clk0      (clk0),
    .reset     (reset),
    .enq_en    (arrive),
    .enq_data  ({ram_rdata1, mpipe[LAST]}),
    .deq_en    (rsp_deq),
    .first     (fifo_first),
    .not_empty (rsp_valid),
    .cnt       (fifo_cnt)
  );

  assign rsp_data = fifo_first[EW-1:N_META_BITS];
  assign rsp_meta = fifo_first[N_META_BITS-1:0];

  a_deq_when_valid: assert property (@(posedge clk0) disable iff (reset)
    rsp_deq |-> rsp_valid)
    else $error("rsp_deq asserted with no response available");

  a_inflight_nonzero: assert property (@(posedge clk0) disable iff (reset)
    arrive |-> (inflight_cnt != '0))
    else $error("read arrived with no read in flight");

endmodule

// File: tb/tb_cci_mpf_prim_ram_rd_flow.sv
// Directed and random checks of the RAM read flow front end, using a
// latency-1 instance (a) and a latency-3 instance (b) over a shared RAM model.
module tb_cci_mpf_prim_ram_rd_flow;

  localparam int NE    = 32;
  localparam int DW    = 64;
  localparam int MW    = 8;
  localparam int AW    = 5;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int NF    = 4;
  localparam int EW    = DW + MW;

  logic clk0    = 1'b0;
  logic reset   = 1'b1;
  logic ram_rdy = 1'b0;

  logic          a_en = 1'b0, b_en = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [MW-1:0] a_meta = '0, b_meta = '0;
  logic          a_deq = 1'b0, b_deq = 1'b0;
  logic          a_rdy, b_rdy, a_valid, b_valid;
  logic [AW-1:0] a_ram_addr, b_ram_addr;
  logic [DW-1:0] a_rdata, b_rdata, a_data, b_data;
  logic [MW-1:0] a_rmeta, b_rmeta;

  logic [DW-1:0] mem [NE];
  logic [AW-1:0] a_ap [LAT_A];
  logic [AW-1:0] b_ap [LAT_B];
  logic [EW-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_proto  = 0;

  always #5 clk0 = ~clk0;

  cci_mpf_prim_ram_rd_flow #(.N_ENTRIES(NE), .N_DATA_BITS(DW), .N_META_BITS(MW),
    .RAM_READ_LATENCY(LAT_A), .N_FIFO_ENTRIES(NF)) dut_a (
    .clk0(clk0), .reset(reset), .ram_rdy(ram_rdy), .rd_req_en(a_en),
    .rd_req_addr(a_addr), .rd_req_meta(a_meta), .rd_req_rdy(a_rdy),
    .ram_addr1(a_ram_addr), .ram_rdata1(a_rdata), .rsp_valid(a_valid),
    .rsp_data(a_data), .rsp_meta(a_rmeta), .rsp_deq(a_deq));

  cci_mpf_prim_ram_rd_flow #(.N_ENTRIES(NE), .N_DATA_BITS(DW), .N_META_BITS(MW),
    .RAM_READ_LATENCY(LAT_B), .N_FIFO_ENTRIES(NF)) dut_b (
    .clk0(clk0), .reset(reset), .ram_rdy(ram_rdy), .rd_req_en(b_en),
    .rd_req_addr(b_addr), .rd_req_meta(b_meta), .rd_req_rdy(b_rdy),
    .ram_addr1(b_ram_addr), .ram_rdata1(b_rdata), .rsp_valid(b_valid),
    .rsp_data(b_data), .rsp_meta(b_rmeta), .rsp_deq(b_deq));

  // RAM model: address registered, data valid LAT cycles after the address.
  always @(posedge clk0) begin
    a_ap[0] <= a_ram_addr;
    b_ap[0] <= b_ram_addr;
    for (int i = 1; i < LAT_B; i++) b_ap[i] <= b_ap[i-1];
  end
  assign a_rdata = mem[a_ap[LAT_A-1]];
  assign b_rdata = mem[b_ap[LAT_B-1]];

  // Handshake protocol: requests only when ready, dequeues only when valid.
  always @(posedge clk0) begin
    if (a_en && !a_rdy) begin n_proto++; $display("FAIL req_while_not_rdy inst=a"); end
    if (b_en && !b_rdy) begin n_proto++; $display("FAIL req_while_not_rdy inst=b"); end
    if (a_deq && !a_valid) begin n_proto++; $display("FAIL deq_while_empty inst=a"); end
    if (b_deq && !b_valid) begin n_proto++; $display("FAIL deq_while_empty inst=b"); end
  end

  task automatic test_reset;
    reset = 1'b1; ram_rdy = 1'b0;
    repeat (3) @(negedge clk0);
    n_checks++;
    if ({a_rdy, b_rdy} !== 2'b00) $display("FAIL reset_rdy got=%b exp=00", {a_rdy, b_rdy});
    else n_pass++;
    n_checks++;
    if ({a_valid, b_valid} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {a_valid, b_valid});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk0);
    n_checks++;
    if ({a_rdy, b_rdy} !== 2'b00) $display("FAIL ram_not_rdy got=%b exp=00", {a_rdy, b_rdy});
    else n_pass++;
    n_checks++;
    if (dut_b.inflight_cnt !== 3'd0) $display("FAIL reset_inflight got=%0d exp=0", dut_b.inflight_cnt);
    else n_pass++;
    ram_rdy = 1'b1;
    @(negedge clk0);
    n_checks++;
    if ({a_rdy, b_rdy} !== 2'b11) $display("FAIL ram_rdy_up got=%b exp=11", {a_rdy, b_rdy});
    else n_pass++;
  endtask

  task automatic test_single;
    int bad = 0;
    a_addr = AW'(5); a_meta = MW'(8'h03); a_en = 1'b1;
    @(negedge clk0);
    a_en = 1'b0;
    for (int j = 0; j <= LAT_A; j++) begin
      if (j > 0) @(negedge clk0);
      if (a_valid !== (j == LAT_A)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL single_latency bad_cycles=%0d exp=0", bad);
    else n_pass++;
    n_checks++;
    if (a_data !== 64'hA5A5) $display("FAIL single_data got=%h exp=%h", a_data, 64'hA5A5);
    else n_pass++;
    n_checks++;
    if (a_rmeta !== 8'h03) $display("FAIL single_meta got=%h exp=03", a_rmeta);
    else n_pass++;
    a_deq = 1'b1;
    @(negedge clk0);
    a_deq = 1'b0;
    n_checks++;
    if (a_valid !== 1'b0) $display("FAIL single_empty got=%b exp=0", a_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int got = 0, bubbles = 0, rdy_miss = 0;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (a_valid) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected got=%h exp=none", {a_data, a_rmeta});
        else if ({a_data, a_rmeta} !== exp_q[0])
          $display("FAIL b2b_data idx=%0d got=%h exp=%h", got, {a_data, a_rmeta}, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
        a_deq = 1'b1;
      end else begin
        a_deq = 1'b0;
        if (got > 0) bubbles++;
      end
      if (c < 16) begin
        if (!a_rdy) rdy_miss++;
        a_en   = a_rdy;
        a_addr = AW'(c);
        a_meta = MW'(c) ^ 8'h5A;
        if (a_en) exp_q.push_back({mem[AW'(c)], MW'(c) ^ 8'h5A});
      end else a_en = 1'b0;
      @(negedge clk0);
    end
    a_en = 1'b0; a_deq = 1'b0;
    n_checks++;
    if (got != 16) $display("FAIL b2b_count got=%0d exp=16", got); else n_pass++;
    n_checks++;
    if (bubbles != 0) $display("FAIL b2b_bubbles got=%0d exp=0", bubbles); else n_pass++;
    n_checks++;
    if (rdy_miss != 0) $display("FAIL b2b_rdy_stall got=%0d exp=0", rdy_miss); else n_pass++;
  endtask

  task automatic test_credit;
    int accepted = 0;
    exp_q.delete();
    b_deq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_en   = b_rdy;
      b_addr = AW'(i + 8);
      b_meta = MW'(i + 16);
      if (b_en) begin accepted++; exp_q.push_back({mem[AW'(i + 8)], MW'(i + 16)}); end
      @(negedge clk0);
    end
    b_en = 1'b0;
    n_checks++;
    if (accepted != NF) $display("FAIL credit_accepted got=%0d exp=%0d", accepted, NF); else n_pass++;
    n_checks++;
    if (b_rdy !== 1'b0) $display("FAIL credit_rdy_low got=%b exp=0", b_rdy); else n_pass++;
    repeat (LAT_B + 1) @(negedge clk0);
    n_checks++;
    if ({b_valid, b_rdy} !== 2'b10) $display("FAIL credit_full got=%b exp=10", {b_valid, b_rdy});
    else n_pass++;
    n_checks++;
    if ({b_data, b_rmeta} !== exp_q[0]) $display("FAIL credit_head got=%h exp=%h", {b_data, b_rmeta}, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    b_deq = 1'b1;
    @(negedge clk0);
    b_deq = 1'b0;
    n_checks++;
    if (b_rdy !== 1'b1) $display("FAIL credit_after_deq got=%b exp=1", b_rdy); else n_pass++;
    b_en = 1'b1; b_addr = AW'(20); b_meta = MW'(8'h77);
    exp_q.push_back({mem[20], 8'h77});
    @(negedge clk0);
    b_en = 1'b0;
    n_checks++;
    if (b_rdy !== 1'b0) $display("FAIL credit_one_more got=%b exp=0", b_rdy); else n_pass++;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (b_valid) begin
        n_checks++;
        if ({b_data, b_rmeta} !== exp_q[0])
          $display("FAIL credit_drain got=%h exp=%h", {b_data, b_rmeta}, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        b_deq = 1'b1;
      end else b_deq = 1'b0;
      @(negedge clk0);
    end
    b_deq = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || b_valid !== 1'b0)
      $display("FAIL credit_drained left=%0d valid=%b exp=0/0", exp_q.size(), b_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      b_en = b_rdy; b_addr = AW'(i); b_meta = MW'(i);
      @(negedge clk0);
    end
    b_en = 1'b0;
    @(negedge clk0);
    n_checks++;
    if (dut_b.inflight_cnt !== 3'd2 || dut_b.fifo_cnt !== 3'd2)
      $display("FAIL mid_setup inflight=%0d fifo=%0d exp=2/2", dut_b.inflight_cnt, dut_b.fifo_cnt);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk0);
    n_checks++;
    if ({b_valid, b_rdy} !== 2'b00 || dut_b.inflight_cnt !== 3'd0)
      $display("FAIL mid_reset valid_rdy=%b inflight=%0d exp=00/0", {b_valid, b_rdy}, dut_b.inflight_cnt);
    else n_pass++;
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk0);
      if (b_valid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL mid_stale got=%0d exp=0", stale); else n_pass++;
    n_checks++;
    if (b_rdy !== 1'b1) $display("FAIL mid_rdy_back got=%b exp=1", b_rdy); else n_pass++;
  endtask

  task automatic test_random;
    int errs = 0, n_rsp = 0;
    logic [AW-1:0] ad;
    logic [MW-1:0] md;
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      if (b_valid && ($urandom_range(0, 99) < 50)) begin
        if (exp_q.size() == 0 || {b_data, b_rmeta} !== exp_q[0]) begin
          errs++;
          if (errs < 10) $display("FAIL random_data cycle=%0d got=%h exp=%h", c, {b_data, b_rmeta},
                                  (exp_q.size() != 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n_rsp++;
        b_deq = 1'b1;
      end else b_deq = 1'b0;
      ram_rdy = ($urandom_range(0, 9) != 0);
      #1;
      ad = AW'($urandom_range(0, NE - 1));
      md = MW'($urandom_range(0, 255));
      b_en = b_rdy && ($urandom_range(0, 99) < 60);
      b_addr = ad; b_meta = md;
      if (b_en) exp_q.push_back({mem[ad], md});
      @(negedge clk0);
    end
    b_en = 1'b0; ram_rdy = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (b_valid) begin
        if ({b_data, b_rmeta} !== exp_q[0]) errs++;
        void'(exp_q.pop_front());
        n_rsp++;
        b_deq = 1'b1;
      end else b_deq = 1'b0;
      @(negedge clk0);
    end
    b_deq = 1'b0;
    n_checks++;
    if (errs != 0) $display("FAIL random_mismatches got=%0d exp=0", errs); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || n_rsp < 1000)
      $display("FAIL random_drain left=%0d responses=%0d exp=0/>=1000", exp_q.size(), n_rsp);
    else n_pass++;
    n_checks++;
    if (b_valid !== 1'b0) $display("FAIL random_empty got=%b exp=0", b_valid); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < NE; i++) mem[i] = {$urandom(), $urandom()};
    mem[5] = 64'hA5A5;
    test_reset();
    test_single();
    test_back_to_back();
    test_credit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks + n_proto);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
